// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter uses the slave modport; the environment (requesters + memory) uses master.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  // fetch requester
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;

  // data requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // memory port
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_gnt;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_gnt, m_rvalid, m_rdata,
    output busy
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_gnt, m_rvalid, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-outstanding memory arbiter.
// Optional macro ARB_RR_EN: alternate ties between requesters instead of fixed data priority.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MREQ  = 2'd1;
  localparam logic [1:0] S_MRESP = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_grant;
  logic          w_resp;
  logic          w_pick_d;

  logic          r_id_d;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;

  logic          r_f_rvalid;
  logic          r_d_rvalid;
  logic [DW-1:0] r_f_rdata;
  logic [DW-1:0] r_d_rdata;

`ifdef ARB_RR_EN
  // r_last_f = 1 means fetch won the most recent grant, so data wins the next tie
  logic r_last_f;

  always_comb begin
    w_pick_d = bus.d_req;
    if (bus.f_req && bus.d_req) begin
      w_pick_d = r_last_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_f <= 1'b1;
    end else if (w_grant) begin
      r_last_f <= ~w_pick_d;
    end
  end
`else
  assign w_pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; grants only in IDLE, memory responses only honoured in MRESP
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_MREQ;
        end
      end
      S_MREQ: begin
        if (bus.m_gnt) begin
          w_state_nxt = S_MRESP;
        end
      end
      S_MRESP: begin
        if (bus.m_rvalid) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch; fetches are always reads with no byte enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_d  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_grant) begin
      r_id_d  <= w_pick_d;
      r_we    <= w_pick_d & bus.d_we;
      r_addr  <= w_pick_d ? bus.d_addr  : bus.f_addr;
      r_wdata <= w_pick_d ? bus.d_wdata : '0;
      r_wstrb <= w_pick_d ? bus.d_wstrb : '0;
    end
  end

  // Response routing; write acks leave d_rdata untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_f_rvalid <= w_resp & ~r_id_d;
      r_d_rvalid <= w_resp & r_id_d;
      if (w_resp && !r_id_d) begin
        r_f_rdata <= bus.m_rdata;
      end
      if (w_resp && r_id_d && !r_we) begin
        r_d_rdata <= bus.m_rdata;
      end
    end
  end

  assign bus.f_gnt    = w_grant & ~w_pick_d;
  assign bus.d_gnt    = w_grant & w_pick_d;
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.f_rdata  = r_f_rdata;
  assign bus.d_rdata  = r_d_rdata;

  assign bus.m_req    = (r_state == S_MREQ);
  assign bus.m_we     = r_we;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.m_wstrb  = r_wstrb;

  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration and response routing.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who won last, and what each requester's rdata should read
  bit            mdl_last_f;
  logic [DW-1:0] mdl_f_rdata;
  logic [DW-1:0] mdl_d_rdata;

  function automatic bit mdl_pick_d(input bit f, input bit d);
`ifdef ARB_RR_EN
    if (f && d) return mdl_last_f;
`endif
    return d;
  endfunction

  task automatic mdl_reset();
    mdl_last_f  = 1'b1;
    mdl_f_rdata = '0;
    mdl_d_rdata = '0;
  endtask

  task automatic clear_inputs();
    bus.f_req    = 1'b0;
    bus.f_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_wstrb  = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    mdl_reset();
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    n_checks++; if (bus.m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got=%0b exp=0", bus.m_req); end
    n_checks++; if ({bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid}); end
    n_checks++; if (bus.f_rdata !== '0 || bus.d_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.f_rdata, bus.d_rdata); end
    n_checks++; if (bus.m_addr !== '0 || bus.m_wdata !== '0 || bus.m_we !== 1'b0 || bus.m_wstrb !== '0) begin
      n_fail++; $display("FAIL reset_cmd got=%h/%h/%0b/%h exp=0", bus.m_addr, bus.m_wdata, bus.m_we, bus.m_wstrb); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.f_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req got=busy%0b gnt%0b%0b exp=0", bus.busy, bus.f_gnt, bus.d_gnt); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h100;
    #1;
    n_checks++; if (bus.f_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gnt_c0 got=f%0b d%0b exp=f1 d0", bus.f_gnt, bus.d_gnt); end
    mdl_last_f = 1'b1;
    @(negedge clk);
    bus.f_req = 1'b0; bus.m_gnt = 1'b1;
    #1;
    n_checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_we !== 1'b0 || bus.m_wstrb !== '0) begin
      n_fail++; $display("FAIL fetch_mreq_c1 got=req%0b addr%h we%0b strb%h exp=req1 addr100 we0 strb0",
                         bus.m_req, bus.m_addr, bus.m_we, bus.m_wstrb); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_c1 got=%0b exp=1", bus.busy); end
    @(negedge clk);
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (bus.m_req !== 1'b0 || bus.f_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_c2 got=mreq%0b frv%0b exp=0/0", bus.m_req, bus.f_rvalid); end
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    #1;
    mdl_f_rdata = 32'hDEADBEEF;
    n_checks++; if (bus.f_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.f_rdata !== mdl_f_rdata) begin
      n_fail++; $display("FAIL fetch_rvalid_c3 got=frv%0b drv%0b data%h exp=1/0/%h",
                         bus.f_rvalid, bus.d_rvalid, bus.f_rdata, mdl_f_rdata); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_c3 got=%0b exp=0", bus.busy); end
    @(negedge clk); #1;
    n_checks++; if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== mdl_f_rdata) begin
      n_fail++; $display("FAIL fetch_c4 got=frv%0b data%h exp=0/%h", bus.f_rvalid, bus.f_rdata, mdl_f_rdata); end
  endtask

  task automatic test_write_delay();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'hF;
    #1;
    n_checks++; if (bus.d_gnt !== 1'b1 || bus.f_gnt !== 1'b0) begin
      n_fail++; $display("FAIL wr_gnt got=d%0b f%0b exp=d1 f0", bus.d_gnt, bus.f_gnt); end
    mdl_last_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.d_req = 1'b0; bus.d_wdata = 32'hFFFF0000; bus.d_addr = 32'h0;
      bus.m_gnt = (k == 3);
      #1;
      n_checks++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h200 ||
                      bus.m_wdata !== 32'h12345678 || bus.m_wstrb !== 4'hF) begin
        n_fail++; $display("FAIL wr_hold_%0d got=req%0b we%0b addr%h data%h strb%h exp=1/1/200/12345678/f",
                           k, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb); end
    end
    @(negedge clk);
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD0BAD0;
    #1;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b1 || bus.f_rvalid !== 1'b0 || bus.d_rdata !== mdl_d_rdata) begin
      n_fail++; $display("FAIL wr_ack got=drv%0b frv%0b drdata%h exp=1/0/%h",
                         bus.d_rvalid, bus.f_rvalid, bus.d_rdata, mdl_d_rdata); end
    @(negedge clk); #1;
    n_checks++; if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse got=%0b exp=0", bus.d_rvalid); end
  endtask

  // Both requesters held high across four transactions from a fresh reset
  task automatic test_arb_order();
    bit exp_d;
    bit prev_d;
    test_reset();
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h400; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      n_checks++; if (bus.d_gnt !== exp_d || bus.f_gnt !== !exp_d) begin
        n_fail++; $display("FAIL arb_order_%0d got=d%0b f%0b exp=d%0b f%0b", t, bus.d_gnt, bus.f_gnt, exp_d, !exp_d); end
      if (t > 0) begin
        n_checks++; if (bus.d_rvalid !== prev_d || bus.f_rvalid !== !prev_d) begin
          n_fail++; $display("FAIL arb_rvalid_%0d got=d%0b f%0b exp=d%0b", t, bus.d_rvalid, bus.f_rvalid, prev_d); end
      end
      mdl_last_f = !exp_d;
      prev_d = exp_d;
      @(negedge clk); bus.m_gnt = 1'b1;
      @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1000 + t;
      @(negedge clk); bus.m_rvalid = 1'b0;
      if (exp_d) mdl_d_rdata = 32'h1000 + t; else mdl_f_rdata = 32'h1000 + t;
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    #1;
    n_checks++; if (bus.f_rdata !== mdl_f_rdata || bus.d_rdata !== mdl_d_rdata) begin
      n_fail++; $display("FAIL arb_rdata got=%h/%h exp=%h/%h", bus.f_rdata, bus.d_rdata, mdl_f_rdata, mdl_d_rdata); end
  endtask

  task automatic test_reset_mresp();
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h180;
    #1;
    @(negedge clk); bus.f_req = 1'b0; bus.m_gnt = 1'b1;
    @(negedge clk); bus.m_gnt = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mresp_pre got=%0b exp=1", bus.busy); end
    @(negedge clk);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.m_req !== 1'b0 || bus.f_rdata !== '0 || bus.d_rdata !== '0) begin
      n_fail++; $display("FAIL rst_mresp_async got=busy%0b mreq%0b rdata%h/%h exp=0",
                         bus.busy, bus.m_req, bus.f_rdata, bus.d_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.m_rvalid = 1'b1; bus.m_rdata = 32'h55555555;
    @(negedge clk); bus.m_rvalid = 1'b0;
    #1;
    n_checks++; if (bus.f_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0 || bus.f_rdata !== mdl_f_rdata) begin
      n_fail++; $display("FAIL rst_stale_rvalid got=frv%0b drv%0b busy%0b fdata%h exp=0/0/0/%h",
                         bus.f_rvalid, bus.d_rvalid, bus.busy, bus.f_rdata, mdl_f_rdata); end
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h300;
    #1;
    n_checks++; if (bus.f_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_next_gnt got=%0b exp=1", bus.f_gnt); end
    mdl_last_f = 1'b1;
    @(negedge clk); bus.f_req = 1'b0; bus.m_gnt = 1'b1;
    #1;
    n_checks++; if (bus.m_addr !== 32'h300) begin n_fail++; $display("FAIL rst_next_addr got=%h exp=300", bus.m_addr); end
    @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFEF00D;
    @(negedge clk); bus.m_rvalid = 1'b0;
    mdl_f_rdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== mdl_f_rdata) begin
      n_fail++; $display("FAIL rst_next_resp got=frv%0b data%h exp=1/%h", bus.f_rvalid, bus.f_rdata, mdl_f_rdata); end
  endtask

  task automatic test_spurious_rvalid();
    @(negedge clk);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h240;
    #1;
    n_checks++; if (bus.f_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_idle got=frv%0b drv%0b busy%0b exp=0/0/0", bus.f_rvalid, bus.d_rvalid, bus.busy); end
    n_checks++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL spur_gnt got=%0b exp=1", bus.d_gnt); end
    mdl_last_f = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    #1;
    n_checks++; if (bus.m_req !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.d_rdata !== mdl_d_rdata) begin
      n_fail++; $display("FAIL spur_mreq got=mreq%0b drv%0b data%h exp=1/0/%h", bus.m_req, bus.d_rvalid, bus.d_rdata, mdl_d_rdata); end
    bus.m_gnt = 1'b1;
    @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h600DD00D;
    @(negedge clk); bus.m_rvalid = 1'b0;
    mdl_d_rdata = 32'h600DD00D;
    #1;
    n_checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== mdl_d_rdata) begin
      n_fail++; $display("FAIL spur_resp got=drv%0b data%h exp=1/%h", bus.d_rvalid, bus.d_rdata, mdl_d_rdata); end
  endtask

  // Random transactions with random memory latency and request noise while busy
  task automatic test_random();
    bit            fr, dr, we, exp_d;
    logic [AW-1:0] fa, da, exp_addr;
    logic [DW-1:0] wd, rd, exp_wd;
    logic [SW-1:0] ws, exp_ws;
    int            gdly, rdly;
    for (int it = 0; it < 60; it++) begin
      fr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      fa = AW'($urandom); da = AW'($urandom); wd = DW'($urandom); ws = SW'($urandom);
      @(negedge clk);
      bus.f_req = fr; bus.f_addr = fa;
      bus.d_req = dr; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd; bus.d_wstrb = ws;
      #1;
      exp_d = mdl_pick_d(fr, dr);
      n_checks++; if (bus.f_gnt !== (fr && !exp_d) || bus.d_gnt !== (dr && exp_d)) begin
        n_fail++; $display("FAIL rnd_gnt_%0d got=f%0b d%0b exp=f%0b d%0b", it, bus.f_gnt, bus.d_gnt, fr && !exp_d, dr && exp_d); end
      if (!fr && !dr) continue;
      mdl_last_f = !exp_d;
      exp_addr = exp_d ? da : fa;
      exp_wd   = exp_d ? wd : '0;
      exp_ws   = exp_d ? ws : '0;
      gdly = $urandom_range(0, 3);
      rdly = $urandom_range(0, 2);
      for (int k = 0; k <= gdly; k++) begin
        @(negedge clk);
        bus.f_req = 1'($urandom_range(0, 1)); bus.d_req = 1'($urandom_range(0, 1));
        bus.d_addr = AW'($urandom); bus.d_wdata = DW'($urandom); bus.f_addr = AW'($urandom);
        bus.m_gnt = (k == gdly);
        #1;
        n_checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== exp_addr || bus.m_we !== (exp_d && we) ||
                        bus.m_wdata !== exp_wd || bus.m_wstrb !== exp_ws || bus.f_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
          n_fail++; $display("FAIL rnd_cmd_%0d got=req%0b addr%h we%0b wd%h ws%h gnt%0b%0b exp=1/%h/%0b/%h/%h/00",
                             it, bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata, bus.m_wstrb, bus.f_gnt, bus.d_gnt,
                             exp_addr, exp_d && we, exp_wd, exp_ws); end
      end
      rd = '0;
      for (int k = 0; k <= rdly; k++) begin
        @(negedge clk);
        bus.m_gnt = 1'b0;
        bus.f_req = 1'($urandom_range(0, 1)); bus.d_req = 1'($urandom_range(0, 1));
        bus.m_rvalid = (k == rdly);
        bus.m_rdata = DW'($urandom);
        rd = bus.m_rdata;
        #1;
        n_checks++; if (bus.m_req !== 1'b0 || bus.f_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 ||
                        bus.f_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
          n_fail++; $display("FAIL rnd_wait_%0d got=mreq%0b rv%0b%0b gnt%0b%0b exp=0", it, bus.m_req,
                             bus.f_rvalid, bus.d_rvalid, bus.f_gnt, bus.d_gnt); end
      end
      @(negedge clk);
      bus.m_rvalid = 1'b0; bus.m_rdata = DW'($urandom);
      bus.f_req = 1'b0; bus.d_req = 1'b0;
      #1;
      if (!exp_d) mdl_f_rdata = rd;
      else if (!we) mdl_d_rdata = rd;
      n_checks++; if (bus.f_rvalid !== !exp_d || bus.d_rvalid !== exp_d || bus.busy !== 1'b0 ||
                      bus.f_rdata !== mdl_f_rdata || bus.d_rdata !== mdl_d_rdata) begin
        n_fail++; $display("FAIL rnd_resp_%0d got=rv%0b%0b busy%0b data%h/%h exp=rv%0b%0b busy0 data%h/%h", it,
                           bus.f_rvalid, bus.d_rvalid, bus.busy, bus.f_rdata, bus.d_rdata,
                           !exp_d, exp_d, mdl_f_rdata, mdl_d_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_delay();
    test_arb_order();
    test_reset_mresp();
    test_spurious_rvalid();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
